// File: rtl/color_batch_unpacker.sv
// color_batch_unpacker: takes BATCH_SIZE-byte batch words and emits them one
// byte per cycle, byte 0 first, with a current/next slot pair for no bubbles.
// Ports: I_rgb_clk, I_rst_n (async low), I_batch_color/I_batch_valid/
// O_batch_ready (batch in), O_color/O_color_valid/I_color_ready/O_color_last
// (byte out), I_flush (only when COLOR_UNPACKER_FLUSH_EN is defined).
module color_batch_unpacker #(
    parameter int BATCH_SIZE = 8
) (
    input  logic                    I_rgb_clk,
    input  logic                    I_rst_n,
    input  logic [8*BATCH_SIZE-1:0] I_batch_color,
    input  logic                    I_batch_valid,
    output logic                    O_batch_ready,
    output logic [7:0]              O_color,
    output logic                    O_color_valid,
    input  logic                    I_color_ready,
`ifdef COLOR_UNPACKER_FLUSH_EN
    input  logic                    I_flush,
`endif
    output logic                    O_color_last
);

    localparam int W  = 8 * BATCH_SIZE;
    localparam int IW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BATCH_SIZE - 1);

    logic [W-1:0]  cur_data;
    logic [W-1:0]  nxt_data;
    logic          cur_v;
    logic          nxt_v;
    logic [IW-1:0] idx;

    logic xfer;
    logic at_last;
    logic done;
    logic accept;
    logic load_cur;
    logic load_nxt;

    always_comb begin
`ifdef COLOR_UNPACKER_FLUSH_EN
        O_batch_ready = !nxt_v && !I_flush;
`else
        O_batch_ready = !nxt_v;
`endif
        xfer     = cur_v && I_color_ready;
        at_last  = (idx == LAST_IDX);
        done     = xfer && at_last;
        accept   = I_batch_valid && O_batch_ready;
        // accept implies nxt is empty, so a finishing cur can be refilled
        load_cur = accept && (!cur_v || done);
        load_nxt = accept && cur_v && !done;
    end

    assign O_color       = cur_data[8*idx +: 8];
    assign O_color_valid = cur_v;
    assign O_color_last  = cur_v && at_last;

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cur_data <= '0;
            nxt_data <= '0;
            cur_v    <= 1'b0;
            nxt_v    <= 1'b0;
            idx      <= '0;
        end else
`ifdef COLOR_UNPACKER_FLUSH_EN
        if (I_flush) begin
            cur_v <= 1'b0;
            nxt_v <= 1'b0;
            idx   <= '0;
        end else
`endif
        begin
            if (load_cur) begin
                cur_data <= I_batch_color;
                cur_v    <= 1'b1;
                idx      <= '0;
            end else if (done && nxt_v) begin
                // promote the waiting batch with no idle cycle
                cur_data <= nxt_data;
                nxt_v    <= 1'b0;
                idx      <= '0;
            end else if (done) begin
                cur_v <= 1'b0;
                idx   <= '0;
            end else if (xfer) begin
                idx <= idx + IW'(1);
            end
            if (load_nxt) begin
                nxt_data <= I_batch_color;
                nxt_v    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_color_batch_unpacker.sv
// tb_color_batch_unpacker: randomized and directed checks of
// color_batch_unpacker (BATCH_SIZE 8 and 1) against a byte-queue model.
module tb_color_batch_unpacker;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [8*N-1:0] bc;
    logic         bv, br, cv, cr, cl;
    logic [7:0]   col;
    logic [7:0]   bc1;
    logic         bv1, br1, cv1, cr1, cl1;
    logic [7:0]   col1;
`ifdef COLOR_UNPACKER_FLUSH_EN
    logic         fl;
    logic         fl1;
`endif

    always #5 clk = ~clk;

    color_batch_unpacker #(.BATCH_SIZE(N)) dut (
        .I_rgb_clk(clk), .I_rst_n(rst_n),
        .I_batch_color(bc), .I_batch_valid(bv), .O_batch_ready(br),
        .O_color(col), .O_color_valid(cv), .I_color_ready(cr),
`ifdef COLOR_UNPACKER_FLUSH_EN
        .I_flush(fl),
`endif
        .O_color_last(cl)
    );

    color_batch_unpacker #(.BATCH_SIZE(1)) dut1 (
        .I_rgb_clk(clk), .I_rst_n(rst_n),
        .I_batch_color(bc1), .I_batch_valid(bv1), .O_batch_ready(br1),
        .O_color(col1), .O_color_valid(cv1), .I_color_ready(cr1),
`ifdef COLOR_UNPACKER_FLUSH_EN
        .I_flush(fl1),
`endif
        .O_color_last(cl1)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic [7:0] q1[$];

    task automatic check(input string nm, input logic [63:0] a,
                         input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // model: bytes still owed, in order; batches held = ceil(bytes/N)
    task automatic compare(input int lit);
        int p;
        p = q.size();
        check("valid", cv, p > 0);
        check("ready", br, ((p + N - 1) / N) < 2);
        if (p > 0) begin
            check("color", col, q[0]);
            check("last", cl, ((p - 1) % N) == 0);
        end
        if (lit >= 0) begin
            check("lit_color", col, lit);
            check("lit_last", cl, lit % N == 0);
        end
    endtask

    task automatic step(input bit v, input logic [8*N-1:0] d,
                        input bit r, input int lit);
        int p;
        bit mr;
        @(negedge clk);
        compare(lit);
        bv = v; bc = d; cr = r;
        @(posedge clk);
        p  = q.size();
        mr = ((p + N - 1) / N) < 2;
        if (p > 0 && r) void'(q.pop_front());
        if (v && mr)
            for (int k = 0; k < N; k++) q.push_back(d[8*k +: 8]);
    endtask

    function automatic logic [8*N-1:0] seq_batch(input int b);
        logic [8*N-1:0] w;
        for (int k = 0; k < N; k++) w[8*k +: 8] = 8'(b * N + k + 1);
        return w;
    endfunction

    function automatic logic [8*N-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 100) begin
            step(0, rnd(), 1, -1);
            guard++;
        end
        check("drain_bound", q.size(), 0);
    endtask

    initial begin
        int b, got, cnt;
        rst_n = 1'b0; bv = 0; bc = '0; cr = 0;
        bv1 = 0; bc1 = '0; cr1 = 0;
`ifdef COLOR_UNPACKER_FLUSH_EN
        fl = 0; fl1 = 0;
`endif
        #1;
        check("rst_valid", cv, 0);
        check("rst_ready", br, 1);
        check("rst_color", col, 0);
        check("rst_last", cl, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single batch, literal bytes 01..08
        step(1, 64'h0807060504030201, 1, -1);
        for (int k = 0; k < N; k++) step(0, rnd(), 1, k + 1);
        step(0, rnd(), 1, -1);

        // four back-to-back batches, bytes 1..32 with no gap
        b = 0; got = 0; cnt = 0;
        while ((b < 4 || q.size() > 0) && cnt < 100) begin
            int ps;
            bit acc;
            ps  = q.size();
            acc = b < 4 && ((ps + N - 1) / N) < 2;
            step(b < 4, seq_batch(b < 4 ? b : 0), 1, ps > 0 ? got + 1 : -1);
            if (ps > 0) got++;
            if (acc) b++;
            cnt++;
        end
        check("seq_count", got, 4 * N);

        // backpressure 1,0,0,1 with three batches offered
        b = 0; cnt = 0;
        while ((b < 3 || q.size() > 0) && cnt < 200) begin
            bit acc;
            acc = b < 3 && ((q.size() + N - 1) / N) < 2;
            step(b < 3, rnd(), (cnt % 4 == 0) || (cnt % 4 == 3), -1);
            if (acc) b++;
            cnt++;
        end
        check("bp_drained", q.size(), 0);

        // boundary: new batch offered as last byte transfers
        step(1, seq_batch(0), 1, -1);
        for (int k = 0; k < N - 1; k++) step(0, rnd(), 1, k + 1);
        step(1, seq_batch(5), 1, N);
        step(0, rnd(), 1, 5 * N + 1);
        drain();

        // reset at byte 3
        step(1, seq_batch(1), 1, -1);
        for (int k = 0; k < 3; k++) step(0, rnd(), 1, N + k + 1);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1 check("midrst_valid", cv, 0);
        @(negedge clk);
        check("midrst_valid2", cv, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(0, rnd(), 1, -1);
        step(1, seq_batch(2), 1, -1);
        step(0, rnd(), 1, 2 * N + 1);
        drain();

`ifdef COLOR_UNPACKER_FLUSH_EN
        step(1, seq_batch(1), 1, -1);
        step(1, seq_batch(3), 1, -1);
        for (int k = 0; k < 3; k++) step(0, rnd(), 1, -1);
        @(negedge clk);
        compare(-1);
        fl = 1; bv = 1; bc = seq_batch(0); cr = 1;
        #1 check("flush_ready", br, 0);
        @(posedge clk);
        q.delete();
        @(negedge clk);
        fl = 0; bv = 0;
        check("flush_valid", cv, 0);
        for (int k = 0; k < 3; k++) step(0, rnd(), 1, -1);
        step(1, seq_batch(2), 1, -1);
        step(0, rnd(), 1, 2 * N + 1);
        drain();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1) == 1, rnd(), $urandom_range(0, 9) < 7, -1);
        drain();

        // BATCH_SIZE=1: sustained, then random ready
        for (int i = 0; i < 200; i++) begin
            int p;
            @(negedge clk);
            p = q1.size();
            check("b1_valid", cv1, p > 0);
            check("b1_ready", br1, p < 2);
            if (p > 0) begin
                check("b1_color", col1, q1[0]);
                check("b1_last", cl1, 1);
            end
            if (i > 0 && i < 100) check("b1_sustain", cv1, 1);
            bv1 = 1;
            bc1 = 8'($urandom);
            cr1 = (i < 100) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            if (p > 0 && cr1) void'(q1.pop_front());
            if (p < 2) q1.push_back(bc1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
